payload_cw_scheduler: RTL and testbench

PAYLOAD_CW_SCHEDULER -- requirements
Module: payload_cw_scheduler

---
 rtl/payload_cw_scheduler_if.sv | 30 +++
 rtl/payload_cw_scheduler.sv | 160 ++++++++++++++++
 tb/tb_payload_cw_scheduler.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/payload_cw_scheduler_if.sv
// Bundle of frame-request, encoder and payload-stream signals for payload_cw_scheduler.
// The scheduler uses the master view and the frame source/encoder side uses the slave view.
interface payload_cw_scheduler_if;
  logic       frame_start;
  logic [3:0] n_cw;
  logic       enc_rd_en;
  logic       enc_do;
  logic       enc_do_vld;
  logic       pl_do;
  logic       pl_vld;
  logic       pl_sof;
  logic       pl_eof;
  logic [3:0] cw_idx;
  logic       busy;
  logic       frame_done;
  logic       err_timeout;
  logic       err_len;

  modport master (
    input  frame_start, n_cw, enc_do, enc_do_vld,
    output enc_rd_en, pl_do, pl_vld, pl_sof, pl_eof, cw_idx, busy,
           frame_done, err_timeout, err_len
  );

  modport slave (
    output frame_start, n_cw, enc_do, enc_do_vld,
    input  enc_rd_en, pl_do, pl_vld, pl_sof, pl_eof, cw_idx, busy,
           frame_done, err_timeout, err_len
  );
endinterface

// File: rtl/payload_cw_scheduler.sv
// Sequences n_cw encoder codewords into one framed payload stream, with inter-codeword
// gaps, a first-bit timeout and codeword length checking.
module payload_cw_scheduler #(
  parameter int CW_LEN  = 8640,
  parameter int GAP_CYC = 4,
  parameter int TO_CYC  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  payload_cw_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_STREAM = 3'd3,
    S_GAP    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [13:0] LAST_BIT = 14'(CW_LEN - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);
  localparam logic [7:0]  TO_LAST  = 8'(TO_CYC - 1);

  state_t      state_r;
  logic [3:0]  n_cw_r;
  logic [3:0]  cw_idx_r;
  logic [13:0] bit_cnt_r;
  logic [7:0]  to_cnt_r;
  logic [7:0]  gap_cnt_r;
  logic        enc_rd_en_r;
  logic        pl_do_r;
  logic        pl_vld_r;
  logic        pl_sof_r;
  logic        pl_eof_r;
  logic        busy_r;
  logic        frame_done_r;
  logic        err_timeout_r;
  logic        err_len_r;
  logic        last_bit_s;
  logic        last_cw_s;

  // bit_cnt_r is zero on WAIT entry, so the first valid bit in WAIT is bit 0
  assign last_bit_s = (bit_cnt_r == LAST_BIT);
  assign last_cw_s  = (cw_idx_r == (n_cw_r - 4'd1));

  assign bus.enc_rd_en   = enc_rd_en_r;
  assign bus.pl_do       = pl_do_r;
  assign bus.pl_vld      = pl_vld_r;
  assign bus.pl_sof      = pl_sof_r;
  assign bus.pl_eof      = pl_eof_r;
  assign bus.cw_idx      = cw_idx_r;
  assign bus.busy        = busy_r;
  assign bus.frame_done  = frame_done_r;
  assign bus.err_timeout = err_timeout_r;
  assign bus.err_len     = err_len_r;

  // Frame sequencing FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      n_cw_r        <= 4'd0;
      cw_idx_r      <= 4'd0;
      bit_cnt_r     <= 14'd0;
      to_cnt_r      <= 8'd0;
      gap_cnt_r     <= 8'd0;
      enc_rd_en_r   <= 1'b0;
      pl_do_r       <= 1'b0;
      pl_vld_r      <= 1'b0;
      pl_sof_r      <= 1'b0;
      pl_eof_r      <= 1'b0;
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      err_timeout_r <= 1'b0;
      err_len_r     <= 1'b0;
    end else begin
      enc_rd_en_r   <= 1'b0;
      pl_do_r       <= 1'b0;
      pl_vld_r      <= 1'b0;
      pl_sof_r      <= 1'b0;
      pl_eof_r      <= 1'b0;
      frame_done_r  <= 1'b0;
      err_timeout_r <= 1'b0;
      err_len_r     <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.frame_start) begin
            if (bus.n_cw != 4'd0) begin
              n_cw_r      <= bus.n_cw;
              cw_idx_r    <= 4'd0;
              busy_r      <= 1'b1;
              enc_rd_en_r <= 1'b1;
              state_r     <= S_ISSUE;
            end else begin
              frame_done_r <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          to_cnt_r  <= 8'd0;
          bit_cnt_r <= 14'd0;
          state_r   <= S_WAIT;
        end
        S_WAIT, S_STREAM: begin
          pl_do_r  <= bus.enc_do & bus.enc_do_vld;
          pl_vld_r <= bus.enc_do_vld;
          if (bus.enc_do_vld) begin
            pl_sof_r <= (state_r == S_WAIT) && (cw_idx_r == 4'd0);
            if (last_bit_s) begin
              pl_eof_r  <= last_cw_s;
              bit_cnt_r <= 14'd0;
              gap_cnt_r <= 8'd0;
              state_r   <= last_cw_s ? S_DONE : S_GAP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 14'd1;
              state_r   <= S_STREAM;
            end
          end else if (state_r == S_WAIT) begin
            if (to_cnt_r == TO_LAST) begin
              err_timeout_r <= 1'b1;
              busy_r        <= 1'b0;
              state_r       <= S_IDLE;
            end else begin
              to_cnt_r <= to_cnt_r + 8'd1;
            end
          end else begin
            err_len_r <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= S_IDLE;
          end
        end
        S_GAP: begin
          // a bit arriving after the codeword's last bit means the encoder overran
          if (bus.enc_do_vld) begin
            err_len_r <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= S_IDLE;
          end else if (gap_cnt_r == GAP_LAST) begin
            cw_idx_r    <= cw_idx_r + 4'd1;
            enc_rd_en_r <= 1'b1;
            state_r     <= S_ISSUE;
          end else begin
            gap_cnt_r <= gap_cnt_r + 8'd1;
          end
        end
        S_DONE: begin
          frame_done_r <= 1'b1;
          busy_r       <= 1'b0;
          state_r      <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_payload_cw_scheduler.sv
// Directed and randomized bench for payload_cw_scheduler: a latency-programmable encoder
// model feeds the DUT, and frame-level expectations are derived from cycle arithmetic.
module tb_payload_cw_scheduler;
  localparam int CW_LEN  = 8640;
  localparam int GAP_CYC = 4;
  localparam int TO_CYC  = 64;

  logic clk;
  logic rst_n;
  payload_cw_scheduler_if bus();

  payload_cw_scheduler #(.CW_LEN(CW_LEN), .GAP_CYC(GAP_CYC), .TO_CYC(TO_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // event log for the current test
  int rd_cyc[$];
  int vld_cnt, sof_cnt, sof_cyc, eof_cnt, eof_cyc, done_cnt, done_cyc;
  int tout_cnt, tout_cyc, len_cnt, len_cyc, busy_cnt, data_err;
  // whole-run invariants
  int excl_err = 0, wid_err = 0, idx_err = 0;
  logic prev_done = 1'b0, prev_tout = 1'b0, prev_len = 1'b0, prev_rd = 1'b0;

  // encoder model
  int enc_lat    = 5;
  int enc_bits   = CW_LEN;
  bit enc_silent = 1'b0;
  int enc_next   = -1;
  int enc_left   = 0;
  bit exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rd_cyc.delete();
    exp_q.delete();
    vld_cnt = 0; sof_cnt = 0; sof_cyc = -1; eof_cnt = 0; eof_cyc = -1;
    done_cnt = 0; done_cyc = -1; tout_cnt = 0; tout_cyc = -1;
    len_cnt = 0; len_cyc = -1; busy_cnt = 0; data_err = 0;
  endtask

  function automatic int rd_at(input int i);
    if (i < rd_cyc.size()) return rd_cyc[i];
    return -1;
  endfunction

  function automatic logic [12:0] outs();
    return {bus.enc_rd_en, bus.pl_do, bus.pl_vld, bus.pl_sof, bus.pl_eof, bus.cw_idx,
            bus.busy, bus.frame_done, bus.err_timeout, bus.err_len};
  endfunction

  // one clock cycle: observe outputs at the falling edge, then drive this cycle's inputs
  task automatic tick();
    bit b;
    @(negedge clk);
    cyc++;
    if (bus.enc_rd_en) begin
      rd_cyc.push_back(cyc);
      if (!enc_silent) enc_next = cyc + enc_lat;
    end
    if (bus.pl_vld) begin
      vld_cnt++;
      if (exp_q.size() == 0) data_err++;
      else if (bus.pl_do !== exp_q.pop_front()) data_err++;
      if (int'(bus.cw_idx) != (vld_cnt - 1) / CW_LEN) idx_err++;
    end
    if (bus.pl_sof) begin sof_cnt++; sof_cyc = cyc; end
    if (bus.pl_eof) begin eof_cnt++; eof_cyc = cyc; end
    if (bus.frame_done) begin done_cnt++; done_cyc = cyc; end
    if (bus.err_timeout) begin tout_cnt++; tout_cyc = cyc; end
    if (bus.err_len) begin len_cnt++; len_cyc = cyc; end
    if (bus.busy) busy_cnt++;
    if ((bus.frame_done & bus.err_timeout) | (bus.frame_done & bus.err_len) |
        (bus.err_timeout & bus.err_len)) excl_err++;
    if ((bus.frame_done & prev_done) | (bus.err_timeout & prev_tout) |
        (bus.err_len & prev_len) | (bus.enc_rd_en & prev_rd)) wid_err++;
    prev_done = bus.frame_done; prev_tout = bus.err_timeout;
    prev_len = bus.err_len; prev_rd = bus.enc_rd_en;
    bus.frame_start = 1'b0;
    if (enc_next == cyc) begin enc_left = enc_bits; enc_next = -1; end
    if (enc_left > 0) begin
      b = 1'($urandom);
      bus.enc_do = b; bus.enc_do_vld = 1'b1;
      exp_q.push_back(b);
      enc_left--;
    end else begin
      bus.enc_do = 1'($urandom); bus.enc_do_vld = 1'b0;
    end
  endtask

  task automatic start(input logic [3:0] n, output int s);
    bus.frame_start = 1'b1;
    bus.n_cw = n;
    s = cyc;
  endtask

  task automatic wait_end(input string tag, input int limit);
    int n = 0;
    while ((done_cnt + tout_cnt + len_cnt) == 0 && n < limit) begin tick(); n++; end
    chk(tag, 32'((done_cnt + tout_cnt + len_cnt) > 0), 32'd1);
  endtask

  initial begin
    int s, n, lat, steps;
    rst_n = 1'b0;
    bus.frame_start = 1'b0; bus.n_cw = 4'd0; bus.enc_do = 1'b0; bus.enc_do_vld = 1'b0;
    clr();
    repeat (3) tick();
    chk("reset_outputs", 32'(outs()), 32'd0);

    // two codewords, 5-cycle encoder, frame_start on the first cycle after reset release
    enc_lat = 5; enc_bits = CW_LEN; enc_silent = 1'b0;
    rst_n = 1'b1;
    start(4'd2, s);
    tick();
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    wait_end("frame2_bound", 40000);
    chk("frame2_done", 32'(done_cnt), 32'd1);
    chk("frame2_busy_low", 32'(bus.busy), 32'd0);
    chk("frame2_rd_cnt", 32'(rd_cyc.size()), 32'd2);
    chk("frame2_rd0", 32'(rd_at(0)), 32'(s + 1));
    chk("frame2_rd_space", 32'(rd_at(1) - rd_at(0)), 32'(CW_LEN + GAP_CYC + 5));
    chk("frame2_bits", 32'(vld_cnt), 32'(2 * CW_LEN));
    chk("frame2_sof", 32'(sof_cyc), 32'(s + 1 + 5 + 1));
    chk("frame2_eof", 32'(eof_cyc), 32'(rd_at(1) + 5 + CW_LEN));
    chk("frame2_done_cyc", 32'(done_cyc), 32'(eof_cyc + 1));
    chk("frame2_sof_eof_cnt", 32'(sof_cnt * 16 + eof_cnt), 32'd17);
    chk("frame2_data", 32'(data_err), 32'd0);

    // empty frame
    clr(); tick();
    start(4'd0, s);
    repeat (4) tick();
    chk("empty_done_cnt", 32'(done_cnt), 32'd1);
    chk("empty_done_cyc", 32'(done_cyc), 32'(s + 1));
    chk("empty_no_rd", 32'(rd_cyc.size()), 32'd0);
    chk("empty_no_busy", 32'(busy_cnt), 32'd0);

    // silent encoder
    clr(); enc_silent = 1'b1;
    start(4'd1, s);
    wait_end("tout_bound", 500);
    chk("tout_cnt", 32'(tout_cnt), 32'd1);
    chk("tout_cyc", 32'(tout_cyc), 32'(rd_at(0) + 1 + TO_CYC));
    chk("tout_busy_low", 32'(bus.busy), 32'd0);
    chk("tout_no_done", 32'(done_cnt + vld_cnt), 32'd0);

    // encoder drops valid after 100 bits; frame_start lands on the error-pulse cycle
    clr(); enc_silent = 1'b0; enc_bits = 100; lat = $urandom_range(1, 20); enc_lat = lat;
    start(4'd3, s);
    wait_end("drop_bound", 1000);
    chk("drop_rd0", 32'(rd_at(0)), 32'(s + 1));
    chk("drop_len_cnt", 32'(len_cnt), 32'd1);
    chk("drop_len_cyc", 32'(len_cyc), 32'(rd_at(0) + lat + 101));
    chk("drop_bits", 32'(vld_cnt), 32'd100);
    chk("drop_no_eof", 32'(eof_cnt + done_cnt), 32'd0);
    chk("drop_busy_low", 32'(bus.busy), 32'd0);
    chk("drop_data", 32'(data_err), 32'd0);

    // reset in the middle of codeword 1, then a clean single-codeword frame
    clr(); enc_bits = CW_LEN; enc_lat = 5;
    start(4'd2, s);
    tick();
    chk("rst_rd0", 32'(rd_at(0)), 32'(s + 1));
    n = 0;
    while (vld_cnt < CW_LEN + 4000 && n < 30000) begin tick(); n++; end
    chk("rst_reach", 32'(vld_cnt), 32'(CW_LEN + 4000));
    chk("rst_cw_idx", 32'(bus.cw_idx), 32'd1);
    rst_n = 1'b0; enc_left = 0; enc_next = -1;
    tick();
    chk("rst_mid_outputs", 32'(outs()), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_no_pulse", 32'(done_cnt + tout_cnt + len_cnt + eof_cnt), 32'd0);
    clr();
    start(4'd1, s);
    wait_end("post_rst_bound", 20000);
    chk("post_rst_rd0", 32'(rd_at(0)), 32'(s + 1));
    chk("post_rst_bits", 32'(vld_cnt), 32'(CW_LEN));
    chk("post_rst_done", 32'(done_cnt * 16 + eof_cnt), 32'd17);
    chk("post_rst_data", 32'(data_err), 32'd0);

    // frame_start while streaming must be ignored
    clr(); tick();
    start(4'd1, s);
    repeat (500) tick();
    bus.frame_start = 1'b1; bus.n_cw = 4'd3;
    tick();
    chk("ign_cw_idx", 32'(bus.cw_idx), 32'd0);
    wait_end("ign_bound", 20000);
    chk("ign_rd_cnt", 32'(rd_cyc.size()), 32'd1);
    chk("ign_bits", 32'(vld_cnt), 32'(CW_LEN));
    chk("ign_done", 32'(done_cnt * 16 + eof_cnt), 32'd17);
    chk("ign_data", 32'(data_err), 32'd0);

    // randomized latency and start offset
    for (int it = 0; it < 2; it++) begin
      clr();
      steps = $urandom_range(0, 7);
      repeat (steps + 1) tick();
      lat = $urandom_range(1, 30); enc_lat = lat;
      start(4'd1, s);
      wait_end("rnd_bound", 20000);
      chk("rnd_rd0", 32'(rd_at(0)), 32'(s + 1));
      chk("rnd_sof", 32'(sof_cyc), 32'(s + 1 + lat + 1));
      chk("rnd_eof", 32'(eof_cyc), 32'(s + 1 + lat + CW_LEN));
      chk("rnd_done", 32'(done_cyc), 32'(s + 2 + lat + CW_LEN));
      chk("rnd_bits", 32'(vld_cnt), 32'(CW_LEN));
      chk("rnd_data", 32'(data_err), 32'd0);
    end

    repeat (3) tick();
    chk("pulse_exclusive", 32'(excl_err), 32'd0);
    chk("pulse_width", 32'(wid_err), 32'd0);
    chk("cw_idx_stable", 32'(idx_err), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
